// File: rtl/multicycle_uc.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// with a ready handshake on the unified memory and a retired-instruction counter.
module multicycle_uc (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zf,
    input  logic        mem_ready,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic        iorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        memtoReg,
    output logic        regDst,
    output logic        regWrite,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [3:0]  aluOp,
    output logic [1:0]  pcSource,
    output logic [3:0]  state,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;

    state_t      state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        retire;

    // The branch decision is made in the datapath from zf and pcWriteCond.
    logic unused_zf;
    assign unused_zf = zf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h00:        state_d = S_EXEC;
                    6'h23, 6'h2B: state_d = S_MEMADR;
                    6'h04:        state_d = S_BRANCH;
                    6'h08:        state_d = S_IEXEC;
                    6'h02:        state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: state_d = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        instr_count_d = retire ? instr_count_q + 32'd1 : instr_count_q;
    end

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memtoReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = ALU_ADD;
        pcSource    = 2'b00;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = mem_ready;
                pcWrite = mem_ready;
            end
            S_DECODE: aluSrcB = 2'b11;
            S_MEMADR, S_IEXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memtoReg = 1'b1;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_FUNCT;
            end
            S_RWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_IWB:    regWrite = 1'b1;
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = ALU_SUB;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
        // Architectural writes are blocked for the whole reset cycle, whatever state we are in.
        if (rst) begin
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            irWrite     = 1'b0;
            regWrite    = 1'b0;
            memWrite    = 1'b0;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_uc.sv
// Self-checking bench for multicycle_uc: per-cycle vector table through a scoreboard,
// plus hand-written reset, halt, reset-during-wait and counter-wrap sequences.
module tb_multicycle_uc;

    logic        clk = 1'b0;
    logic        rst, zf, mem_ready;
    logic [5:0]  opcode;
    logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic        memtoReg, regDst, regWrite, aluSrcA;
    logic [1:0]  aluSrcB, pcSource;
    logic [3:0]  aluOp, state;
    logic        halted;
    logic [31:0] instr_count;

    multicycle_uc dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zf(zf), .mem_ready(mem_ready),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .memtoReg(memtoReg), .regDst(regDst),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .state(state), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    logic [17:0] act_ctl;
    assign act_ctl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg,
                      regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

    logic [17:0] c_fr, c_fw, c_dec, c_adr, c_mrd, c_mwr, c_mwb, c_exe, c_rwb, c_iwb, c_br, c_jmp, c_zero;

    function automatic logic [17:0] ctl(input logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa,
                                        input logic [1:0] asb, input logic [3:0] aop,
                                        input logic [1:0] ps);
        return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                       input logic [17:0] c, input logic [31:0] cnt);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.ctl = c; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, queue the expectation, then compare once outputs settle.
    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        opcode    = v.op;
        mem_ready = v.mr;
        e.st = v.st; e.ctl = v.ctl; e.cnt = v.cnt;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check($sformatf("step%0d state", step_no), {28'd0, state}, {28'd0, e.st});
        check($sformatf("step%0d ctrl", step_no), {14'd0, act_ctl}, {14'd0, e.ctl});
        check($sformatf("step%0d count", step_no), instr_count, e.cnt);
        step_no++;
    endtask

    task automatic step_a(input logic [5:0] op, input logic mr, input logic [3:0] st,
                          input logic [17:0] c, input logic [31:0] cnt);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.ctl = c; v.cnt = cnt;
        step(v);
    endtask

    initial begin
        c_fr   = ctl(1,0,0,1,0,1,0,0,0,0,2'b01,4'h0,2'b00);
        c_fw   = ctl(0,0,0,1,0,0,0,0,0,0,2'b01,4'h0,2'b00);
        c_dec  = ctl(0,0,0,0,0,0,0,0,0,0,2'b11,4'h0,2'b00);
        c_adr  = ctl(0,0,0,0,0,0,0,0,0,1,2'b10,4'h0,2'b00);
        c_mrd  = ctl(0,0,1,1,0,0,0,0,0,0,2'b00,4'h0,2'b00);
        c_mwr  = ctl(0,0,1,0,1,0,0,0,0,0,2'b00,4'h0,2'b00);
        c_mwb  = ctl(0,0,0,0,0,0,1,0,1,0,2'b00,4'h0,2'b00);
        c_exe  = ctl(0,0,0,0,0,0,0,0,0,1,2'b00,4'h2,2'b00);
        c_rwb  = ctl(0,0,0,0,0,0,0,1,1,0,2'b00,4'h0,2'b00);
        c_iwb  = ctl(0,0,0,0,0,0,0,0,1,0,2'b00,4'h0,2'b00);
        c_br   = ctl(0,1,0,0,0,0,0,0,0,1,2'b00,4'h1,2'b01);
        c_jmp  = ctl(1,0,0,0,0,0,0,0,0,0,2'b00,4'h0,2'b10);
        c_zero = '0;

        // Instruction mix, mem_ready high: 23 cycles
        add(6'h00,1,0,c_fr,0);  add(6'h00,1,1,c_dec,0); add(6'h00,1,6,c_exe,0); add(6'h00,1,7,c_rwb,0);
        add(6'h23,1,0,c_fr,1);  add(6'h23,1,1,c_dec,1); add(6'h23,1,2,c_adr,1); add(6'h23,1,3,c_mrd,1);
        add(6'h23,1,4,c_mwb,1);
        add(6'h2B,1,0,c_fr,2);  add(6'h2B,1,1,c_dec,2); add(6'h2B,1,2,c_adr,2); add(6'h2B,1,5,c_mwr,2);
        add(6'h04,1,0,c_fr,3);  add(6'h04,1,1,c_dec,3); add(6'h04,1,8,c_br,3);
        add(6'h08,1,0,c_fr,4);  add(6'h08,1,1,c_dec,4); add(6'h08,1,9,c_adr,4); add(6'h08,1,10,c_iwb,4);
        add(6'h02,1,0,c_fr,5);  add(6'h02,1,1,c_dec,5); add(6'h02,1,11,c_jmp,5);
        // lw with 3 FETCH waits and 2 MEMRD waits: 10 cycles; mem_ready low elsewhere is ignored
        for (int i = 0; i < 3; i++) add(6'h23,0,0,c_fw,6);
        add(6'h23,1,0,c_fr,6);  add(6'h23,0,1,c_dec,6); add(6'h23,0,2,c_adr,6);
        add(6'h23,0,3,c_mrd,6); add(6'h23,0,3,c_mrd,6); add(6'h23,1,3,c_mrd,6);
        add(6'h23,0,4,c_mwb,6);
        // sw with 4 MEMWR waits: memWrite high for 5 cycles
        add(6'h2B,1,0,c_fr,7);  add(6'h2B,0,1,c_dec,7); add(6'h2B,1,2,c_adr,7);
        for (int i = 0; i < 4; i++) add(6'h2B,0,5,c_mwr,7);
        add(6'h2B,1,5,c_mwr,7);

        zf = 1'b0; opcode = 6'h00; mem_ready = 1'b1; rst = 1'b1;

        // Reset held two cycles; enables blocked even though FETCH sees mem_ready=1
        @(posedge clk); #1;
        check("rst state", {28'd0, state}, 32'd0);
        check("rst count", instr_count, 32'd0);
        check("rst enables", {27'd0, pcWrite, pcWriteCond, irWrite, regWrite, memWrite}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0; #1;
        check("post-rst memRead", {31'd0, memRead}, 32'd1);
        check("post-rst ir/pc wait", {30'd0, irWrite, pcWrite}, 32'd0);
        mem_ready = 1'b1; #1;
        check("post-rst ir/pc ready", {30'd0, irWrite, pcWrite}, 32'b11);
        mem_ready = 1'b0; #1;

        foreach (vecs[i]) step(vecs[i]);

        // Illegal opcode halts; counter untouched; reset recovers
        step_a(6'h3F,1,0,c_fr,8);
        step_a(6'h3F,1,1,c_dec,8);
        step_a(6'h3F,1,15,c_zero,8);
        check("halted", {31'd0, halted}, 32'd1);
        step_a(6'h3F,0,15,c_zero,8);
        check("halted hold", {31'd0, halted}, 32'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
        check("halt-rst state", {28'd0, state}, 32'd0);
        check("halt-rst halted", {31'd0, halted}, 32'd0);
        check("halt-rst count", instr_count, 32'd0);

        // Reset while waiting in MEMRD
        step_a(6'h23,1,0,c_fr,0);
        step_a(6'h23,1,1,c_dec,0);
        step_a(6'h23,0,2,c_adr,0);
        step_a(6'h23,0,3,c_mrd,0);
        rst = 1'b1; #1;
        check("memrd-rst writes", {30'd0, memWrite, regWrite}, 32'd0);
        @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
        check("memrd-rst state", {28'd0, state}, 32'd0);
        check("memrd-rst mw/rw", {30'd0, memWrite, regWrite}, 32'd0);

        // Reset coinciding with a retire: reset wins
        step_a(6'h00,1,0,c_fr,0);
        step_a(6'h00,1,1,c_dec,0);
        step_a(6'h00,1,6,c_exe,0);
        step_a(6'h00,1,7,c_rwb,0);
        step_a(6'h00,0,0,c_fw,1);
        step_a(6'h00,1,0,c_fr,1);
        step_a(6'h00,1,1,c_dec,1);
        step_a(6'h00,1,6,c_exe,1);
        step_a(6'h00,1,7,c_rwb,1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
        check("retire-rst count", instr_count, 32'd0);
        check("retire-rst state", {28'd0, state}, 32'd0);

        // Counter wrap: preload all-ones while idling in FETCH, then retire a beq
        @(negedge clk);
        dut.instr_count_q = 32'hFFFF_FFFF;
        step_a(6'h04,0,0,c_fw,32'hFFFF_FFFF);
        step_a(6'h04,1,0,c_fr,32'hFFFF_FFFF);
        step_a(6'h04,1,1,c_dec,32'hFFFF_FFFF);
        step_a(6'h04,1,8,c_br,32'hFFFF_FFFF);
        step_a(6'h04,0,0,c_fw,32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_uc.md
# multicycle_uc

- Multi-cycle control FSM for the MIPS datapath; replaces the single-cycle UC decoder.
- Sequences fetch, decode, execute, memory and writeback over several clocks.
- Adds a ready handshake with the unified instruction/data memory.
- Supports R-type, lw, sw, beq, addi and j. Any other opcode halts the machine until reset.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction bits [31:26] from the instruction register
- zf  in  1  ALU zero flag
- mem_ready  in  1  memory handshake: the access completes in any cycle where the request is high and mem_ready=1
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load qualified by zf
- iorD  out  1  memory address select: 0=PC, 1=ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- irWrite  out  1  instruction register load
- memtoReg  out  1  write-data select: 0=ALUOut, 1=MDR
- regDst  out  1  destination select: 0=rt, 1=rd
- regWrite  out  1  register file write enable
- aluSrcA  out  1  ALU A select: 0=PC, 1=rs
- aluSrcB  out  2  ALU B select: 00=rt, 01=const 4, 10=signext, 11=signext<<2
- aluOp  out  4  ALU operation: 0000=ADD, 0001=SUB, 0010=use funct
- pcSource  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state, for debug
- halted  out  1  high while in HALT
- instr_count  out  32  count of retired instructions

## Operation
State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, HALT=15
- Codes 12–14 are unused. If one is reached, the next state is FETCH.

Transitions:
- FETCH → DECODE when mem_ready=1; otherwise stay in FETCH.
- DECODE dispatches on opcode:
  - 0x00 → EXEC
  - 0x23 or 0x2B → MEMADR
  - 0x04 → BRANCH
  - 0x08 → IEXEC
  - 0x02 → JUMP
  - any other opcode → HALT
- MEMADR → MEMRD if opcode=0x23, otherwise → MEMWR.
- MEMRD → MEMWB when mem_ready=1; otherwise stay.
- MEMWR → FETCH when mem_ready=1; otherwise stay.
- EXEC → RWB; IEXEC → IWB.
- MEMWB, RWB, IWB, BRANCH and JUMP → FETCH.
- HALT → HALT.

Outputs are decoded combinationally from state, with mem_ready gating where noted. Every output not listed for a state is 0.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=ADD, pcSource=00; irWrite=pcWrite=mem_ready.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=ADD (precomputes the branch target).
- MEMADR and IEXEC: aluSrcA=1, aluSrcB=10, aluOp=ADD.
- MEMRD: memRead=1, iorD=1. MEMWR: memWrite=1, iorD=1. Each request is held until mem_ready.
- MEMWB: regWrite=1, memtoReg=1, regDst=0.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=FUNCT.
- RWB: regWrite=1, regDst=1, memtoReg=0.
- IWB: regWrite=1, regDst=0, memtoReg=0.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=SUB, pcWriteCond=1, pcSource=01. zf is consumed by the datapath, not by this FSM.
- JUMP: pcWrite=1, pcSource=10.
- HALT: halted=1; all enables are 0.

instr_count:
- Increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, IWB, BRANCH or JUMP.
- Wraps from 0xFFFFFFFF to 0.
- Does not increment on entry to HALT.

## Timing
- Reset: on a rising edge with rst=1, state←FETCH and instr_count←0.
  - While rst=1, pcWrite, pcWriteCond, irWrite, regWrite and memWrite are forced to 0 combinationally.
  - rst takes priority over every transition, including mid-wait in MEMRD/MEMWR and in HALT.
- After reset release, the outputs are the FETCH set.
- Latency with mem_ready held high:
  - beq and j: 3 cycles.
  - R-type, addi and sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- mem_ready is ignored in all other states.
- opcode must be stable from DECODE until the instruction retires. The IR is loaded only when irWrite=1.
- Simultaneous rst and a retire transition: reset wins and instr_count becomes 0.

## Test plan
- Reset: rst=1 for 2 cycles, then release → state=0, instr_count=0, memRead=1, and irWrite=pcWrite=mem_ready. No write enables are high during reset.
- Instruction mix, mem_ready=1: add, lw, sw, beq, addi, j → state sequences 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,9,10 / 0,1,11; total 23 cycles; instr_count=6.
- Wait states: lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEMRD → 10 cycles. memRead stays high throughout each wait. irWrite pulses exactly once.
- sw with mem_ready low for 4 cycles in MEMWR → memWrite is high for 5 consecutive cycles, then state=0 and instr_count increments once.
- Illegal opcode 0x3F → DECODE → HALT, halted=1, all enables 0, instr_count unchanged. rst then returns the FSM to FETCH.
- Reset during MEMRD wait → next state=0 with memWrite=0 and regWrite=0. A separate check: instr_count preset to 0xFFFFFFFF retires one instruction and wraps to 0.
